// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_buf receiver: FSM state encoding
// and the oversampling counter width helper.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_e;

   // Counter must hold CLKS_PER_BIT-1; never narrower than one bit.
   function automatic int cnt_width(input int clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on rd_data_o
// whenever empty_o is low; a pop while full may accept a same-cycle push.
module uart_rx_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Head is forced to zero when empty so the output is clean out of reset.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk_i) begin
            if (push_ok && (wr_ptr_q == AW'(gi))) begin
               mem_q[gi] <= wr_data_i;
            end
         end
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with sticky error flags and a FWFT receive buffer.
// Even-parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_buf #(
   parameter int CLKS_PER_BIT = 347,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          core_clk,
   input  logic                          core_rstn,
   input  logic                          ser_rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          frame_err,
   output logic                          overrun_err,
   output logic                          parity_err,
   input  logic                          err_clr
);

   import uart_rx_pkg::*;

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [2:0]             sync_q;
   logic                   rx_s, rx_prev, tick;
   logic                   push, pop, fifo_full, fifo_empty;
   logic                   frame_set, overrun_set;
   logic                   frame_err_q, overrun_err_q;

   // sync_q[1] is the synchronised line; sync_q[2] is its previous value.
   assign rx_s    = sync_q[1];
   assign rx_prev = sync_q[2];
   assign tick    = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d, par_set, parity_err_q;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      par_set   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_prev && !rx_s) begin
               state_d = ST_START;
               cnt_d   = HALF_BIT;
            end
         end
         ST_START: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!rx_s) begin
               state_d = ST_DATA;
               cnt_d   = FULL_BIT;
               bit_d   = '0;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               cnt_d   = FULL_BIT;
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if ((^shift_q) != rx_s) begin
                  par_bad_d = 1'b1;
                  par_set   = 1'b1;
               end
               cnt_d   = FULL_BIT;
               state_d = ST_STOP;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = '0;
               if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                  push = ~par_bad_q;
`else
                  push = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_d   = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         sync_q  <= 3'b111;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[1:0], ser_rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   assign pop         = rx_valid & rx_ready;
   assign overrun_set = push & fifo_full & ~pop;

   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         if (frame_set)    frame_err_q <= 1'b1;
         else if (err_clr) frame_err_q <= 1'b0;
         if (overrun_set)  overrun_err_q <= 1'b1;
         else if (err_clr) overrun_err_q <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         if (par_set)      parity_err_q <= 1'b1;
         else if (err_clr) parity_err_q <= 1'b0;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;
   assign rx_valid    = ~fifo_empty;

   uart_rx_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (core_clk),
      .rst_ni    (core_rstn),
      .push_i    (push),
      .wr_data_i (shift_q),
      .pop_i     (pop),
      .rd_data_o (rx_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (rx_level)
   );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf (CLKS_PER_BIT=8, DATA_BITS=8, FIFO_DEPTH=4);
// define UART_RX_PARITY_EN for both bench and RTL to exercise parity.
module tb_uart_rx_buf;

   localparam int CPB = 8;

   logic       core_clk = 1'b0;
   logic       core_rstn = 1'b0;
   logic       ser_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [2:0] rx_level;
   logic       frame_err, overrun_err, parity_err;
   logic       err_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 core_clk = ~core_clk;

   uart_rx_buf #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .FIFO_DEPTH   (4)
   ) dut (
      .core_clk    (core_clk),
      .core_rstn   (core_rstn),
      .ser_rx      (ser_rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_level    (rx_level),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err),
      .err_clr     (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic bit_out(input logic v);
      ser_rx = v;
      wait_cyc(CPB);
   endtask

   task automatic send(input logic [7:0] d, input logic stop_v, input logic par_flip);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_out((^d) ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored without parity");
`endif
      bit_out(stop_v);
      ser_rx = 1'b1;
      $display("sent frame data=%02h stop=%0b par_flip=%0b", d, stop_v, par_flip);
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      wait_cyc(1);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_valid", rx_valid, 0);
      check("rst_level", rx_level, 0);
      check("rst_data", rx_data, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_oerr", overrun_err, 0);
      check("rst_perr", parity_err, 0);
      wait_cyc(3);
      core_rstn = 1'b1;
      wait_cyc(4);
      check("idle_level", rx_level, 0);

      // Two words, then drain through FWFT head.
      send(8'hA5, 1'b1, 1'b0);
      wait_cyc(2);
      check("a5_valid", rx_valid, 1);
      check("a5_level", rx_level, 1);
      check("a5_data", rx_data, 8'hA5);
      send(8'h3C, 1'b1, 1'b0);
      wait_cyc(2);
      check("two_level", rx_level, 2);
      check("two_head", rx_data, 8'hA5);
      pop_one();
      check("pop1_level", rx_level, 1);
      check("pop1_data", rx_data, 8'h3C);
      pop_one();
      check("pop2_level", rx_level, 0);
      check("pop2_valid", rx_valid, 0);

      // Overrun: fifth word hits a full buffer.
      for (int w = 1; w <= 5; w++) send(8'(w), 1'b1, 1'b0);
      wait_cyc(2);
      check("ovr_level", rx_level, 4);
      check("ovr_flag", overrun_err, 1);
      for (int w = 1; w <= 4; w++) begin
         check($sformatf("ovr_rd%0d", w), rx_data, w);
         pop_one();
      end
      check("ovr_empty", rx_valid, 0);
      check("ovr_flag_sticky", overrun_err, 1);
      pulse_clr();
      check("ovr_clr", overrun_err, 0);

      // Framing error: stop bit low.
      send(8'h3C, 1'b0, 1'b0);
      wait_cyc(6);
      check("ferr_flag", frame_err, 1);
      check("ferr_level", rx_level, 0);
      pulse_clr();
      check("ferr_clr", frame_err, 0);

      // Two-cycle glitch must be ignored.
      ser_rx = 1'b0;
      wait_cyc(2);
      ser_rx = 1'b1;
      wait_cyc(20);
      check("glitch_level", rx_level, 0);
      check("glitch_ferr", frame_err, 0);
      check("glitch_oerr", overrun_err, 0);
      send(8'h55, 1'b1, 1'b0);
      wait_cyc(2);
      check("g55_level", rx_level, 1);
      check("g55_data", rx_data, 8'h55);
      pop_one();

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b1);
      wait_cyc(2);
      check("par_bad_flag", parity_err, 1);
      check("par_bad_level", rx_level, 0);
      pulse_clr();
      check("par_clr", parity_err, 0);
      send(8'h07, 1'b1, 1'b0);
      wait_cyc(2);
      check("par_ok_level", rx_level, 1);
      check("par_ok_data", rx_data, 8'h07);
      check("par_ok_flag", parity_err, 0);
      pop_one();
`endif

      // Reset in the middle of a frame, with a word buffered and an error set.
      send(8'h42, 1'b1, 1'b0);
      send(8'h11, 1'b0, 1'b0);
      wait_cyc(6);
      check("pre_rst_level", rx_level, 1);
      check("pre_rst_ferr", frame_err, 1);
      bit_out(1'b0);
      for (int i = 0; i < 3; i++) bit_out(1'b1);
      @(posedge core_clk);
      #3;
      core_rstn = 1'b0;
      #1;
      check("arst_valid", rx_valid, 0);
      check("arst_level", rx_level, 0);
      check("arst_data", rx_data, 0);
      check("arst_ferr", frame_err, 0);
      check("arst_oerr", overrun_err, 0);
      wait_cyc(3);
      core_rstn = 1'b1;
      wait_cyc(40);
      check("post_rst_level", rx_level, 0);
      send(8'h81, 1'b1, 1'b0);
      wait_cyc(2);
      check("r81_level", rx_level, 1);
      check("r81_data", rx_data, 8'h81);
      check("r81_ferr", frame_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 347: core_clk cycles per serial bit (115200 baud at 40 MHz); minimum 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16: receive buffer entries, power of two, at least 2.
REQ-004 The block SHALL have port core_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port core_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port ser_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, DATA_BITS wide: head-of-buffer word.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: buffer not empty.
REQ-009 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the head word.
REQ-010 The block SHALL have port rx_level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-011 The block SHALL have port frame_err, output, 1 bit: sticky framing error.
REQ-012 The block SHALL have port overrun_err, output, 1 bit: sticky overrun.
REQ-013 The block SHALL have port parity_err, output, 1 bit: sticky parity error (see Configuration).
REQ-014 The block SHALL have port err_clr, input, 1 bit: clears all sticky errors.

Function
REQ-015 ser_rx SHALL pass through a 2-flop synchroniser before use; all later timing is measured from the synchronised signal.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-017 IDLE -> START SHALL occur on a synchronised high-to-low edge; the bit counter loads CLKS_PER_BIT/2.
REQ-018 START SHALL sample the line at the half-bit point: if low, go to DATA; if high, the pulse is a glitch and the FSM returns to IDLE with no side effects.
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples, then go to PARITY if enabled, otherwise to STOP.
REQ-020 STOP SHALL take one sample: high -> push the word and go to IDLE; low -> set frame_err, discard the word, go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL return to IDLE on the first synchronised high sample.
REQ-022 The push SHALL occur in the stop-sample cycle; rx_valid and rx_level SHALL update on the next core_clk edge.
REQ-023 The buffer SHALL be first-word-fall-through: rx_data is the head whenever rx_valid=1; the head pops on a cycle where rx_valid and rx_ready are both 1.
REQ-024 Push while full without a same-cycle pop: the word SHALL be discarded, overrun_err set, and contents unchanged.
REQ-025 Push while full with a same-cycle pop: both SHALL occur and rx_level SHALL stay at FIFO_DEPTH.
REQ-026 Simultaneous push and pop at any other level SHALL leave rx_level unchanged.
REQ-027 rx_data SHALL be don't-care when rx_valid=0.
REQ-028 When err_clr and a new error event fall in the same cycle, the set SHALL win.
REQ-029 err_clr SHALL NOT affect the FSM or the buffer.

Reset
REQ-030 On core_rstn low, the block SHALL immediately force: FSM IDLE; counters 0; synchroniser flops 1; buffer empty; rx_valid, rx_level, rx_data, frame_err, overrun_err and parity_err all 0.
REQ-031 A frame in progress at reset SHALL be abandoned.
REQ-032 After release, the block SHALL ignore the line until the first falling edge.

Configuration
REQ-033 Parity checking SHALL be controlled by macro UART_RX_PARITY_EN.
REQ-034 With UART_RX_PARITY_EN defined: the PARITY state SHALL sample one even-parity bit after the data bits. On mismatch, parity_err is set, the word is discarded after the stop sample, and normal stop handling follows.
REQ-035 Without UART_RX_PARITY_EN: the PARITY state SHALL be unreachable, frames SHALL be 1+DATA_BITS+1 bits, and parity_err SHALL be tied to 0.

Structure
REQ-036 Package uart_rx_pkg SHALL hold the FSM state enum and a localparam function for counter width, $clog2(CLKS_PER_BIT).
REQ-037 The buffer SHALL be a sub-module, uart_rx_sync_fifo, parameterised by width and depth, with push, pop, full, empty and level signals.

Verification (bench: CLKS_PER_BIT=8, DATA_BITS=8, FIFO_DEPTH=4)
REQ-038 Send 0xA5 then 0x3C -> rx_valid=1 with rx_data=0xA5, then 0x3C after one pop; rx_level goes 1, 2, 1, 0.
REQ-039 Send 5 words 0x01..0x05 with rx_ready=0 -> rx_level=4, overrun_err=1, words read back are 0x01..0x04.
REQ-040 Send 0x3C with stop bit forced low -> frame_err=1, rx_level unchanged; pulse err_clr -> frame_err=0.
REQ-041 Drive a 2-cycle low glitch on ser_rx -> no push and no error flags; a following 0x55 is received correctly.
REQ-042 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1 and nothing pushed; with parity bit 1 -> 0x07 is received.
REQ-043 Assert core_rstn low during the data bits of 0xFF -> all outputs return to 0 immediately; a following 0x81 is received intact.
